// File: rtl/timer_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : timer_disp_pkg                                               |
// | Description : Shared types and constants for the timer display scanner.    |
// |               Seven-segment glyphs are active-low, ordered {g,f,e,d,c,b,a}.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package timer_disp_pkg;

    // Active-low glyphs: a 0 bit lights the segment.
    localparam logic [6:0] SEG7_0     = 7'h40;
    localparam logic [6:0] SEG7_1     = 7'h79;
    localparam logic [6:0] SEG7_2     = 7'h24;
    localparam logic [6:0] SEG7_3     = 7'h30;
    localparam logic [6:0] SEG7_4     = 7'h19;
    localparam logic [6:0] SEG7_5     = 7'h12;
    localparam logic [6:0] SEG7_6     = 7'h02;
    localparam logic [6:0] SEG7_7     = 7'h78;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h10;
    localparam logic [6:0] SEG7_DASH  = 7'h3F;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // All digit enables released (active-low anodes).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Digit slot order, rightmost digit first.
    typedef enum logic [1:0] {
        SLOT_SEC2  = 2'd0,
        SLOT_SEC1  = 2'd1,
        SLOT_MIN   = 2'd2,
        SLOT_BLANK = 2'd3
    } slot_t;

    // One-cold anode pattern for a slot; the blank slot never drives its digit.
    function automatic logic [3:0] slot_anode(input slot_t slot);
        logic [3:0] v_an;
        case (slot)
            SLOT_SEC2: v_an = 4'b1110;
            SLOT_SEC1: v_an = 4'b1101;
            SLOT_MIN:  v_an = 4'b1011;
            default:   v_an = AN_OFF;
        endcase
        return v_an;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_to_seg7                                                  |
// | Description : Combinational BCD to active-low seven-segment decoder.       |
// |               Codes 10-15 show a dash (only segment g lit).                |
// | Ports       : i_bcd [3:0] in  - BCD digit                                  |
// |               o_seg [6:0] out - segments {g,f,e,d,c,b,a}, active-low       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bcd_to_seg7
    import timer_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG7_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG7_0;
            4'd1:    o_seg = SEG7_1;
            4'd2:    o_seg = SEG7_2;
            4'd3:    o_seg = SEG7_3;
            4'd4:    o_seg = SEG7_4;
            4'd5:    o_seg = SEG7_5;
            4'd6:    o_seg = SEG7_6;
            4'd7:    o_seg = SEG7_7;
            4'd8:    o_seg = SEG7_8;
            4'd9:    o_seg = SEG7_9;
            default: o_seg = SEG7_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/timer_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_display_scan                                           |
// | Description : Scans the countdown timer's BCD digits onto a 4-digit        |
// |               common-anode display as "M.SS". Digits are latched once per  |
// |               scan frame so one frame never mixes two timer values.        |
// |               Flags time-up (live inputs at 0:00).                         |
// | Macro       : TIMEUP_BLINK_EN - when defined, the display blinks while     |
// |               time_up is high (half-period BLINK_DIV cycles).              |
// | Ports       : clk         in  1  system clock                              |
// |               rst         in  1  asynchronous, active-low reset            |
// |               min         in  4  BCD minutes                               |
// |               sec1        in  4  BCD seconds tens                          |
// |               sec2        in  4  BCD seconds units                         |
// |               an          out 4  digit enables, active-low, an[0] right    |
// |               seg         out 7  segments {g,f,e,d,c,b,a}, active-low      |
// |               dp          out 1  decimal point, active-low                 |
// |               time_up     out 1  live inputs read 0:00 (1-cycle latency)   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module timer_display_scan
    import timer_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 25000000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min,
    input  logic [3:0] sec1,
    input  logic [3:0] sec2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       time_up
);

    localparam int              c_PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(SCAN_DIV - 1);
    localparam logic [c_PW-1:0] c_GUARD     = c_PW'(GUARD);

    logic [c_PW-1:0] r_presc;
    slot_t           r_slot;
    logic [3:0]      r_sh_min;
    logic [3:0]      r_sh_sec1;
    logic [3:0]      r_sh_sec2;

    logic            w_presc_wrap;
    logic            w_in_guard;
    logic            w_live_zero;
    logic [3:0]      w_digit;
    logic [6:0]      w_glyph;
    logic            w_phase_next;

    assign w_presc_wrap = (r_presc == c_PRESC_MAX);
    assign w_in_guard   = (r_presc < c_GUARD);
    assign w_live_zero  = (min == 4'd0) && (sec1 == 4'd0) && (sec2 == 4'd0);

    // Only the shadow copies feed the display, never the live inputs.
    always_comb begin
        w_digit = 4'd0;
        case (r_slot)
            SLOT_SEC2: w_digit = r_sh_sec2;
            SLOT_SEC1: w_digit = r_sh_sec1;
            SLOT_MIN:  w_digit = r_sh_min;
            default:   w_digit = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

`ifdef TIMEUP_BLINK_EN
    localparam int              c_BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_BW-1:0] c_BLINK_MAX = c_BW'(BLINK_DIV - 1);

    logic [c_BW-1:0] r_blink_cnt;
    logic            r_blink_on;

    // Phase the blink register will hold after this edge; the anode register
    // uses it so blanking lines up with the phase change rather than lagging.
    always_comb begin
        w_phase_next = 1'b1;
        if (time_up) begin
            w_phase_next = (r_blink_cnt == c_BLINK_MAX) ? ~r_blink_on : r_blink_on;
        end
    end

    // Counter idles at 0 with the phase on so each new time-up starts visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_on <= w_phase_next;
            if (!time_up || (r_blink_cnt == c_BLINK_MAX)) begin
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end
`else
    assign w_phase_next = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            r_slot    <= SLOT_SEC2;
            r_sh_min  <= 4'd0;
            r_sh_sec1 <= 4'd0;
            r_sh_sec2 <= 4'd0;
            an        <= AN_OFF;
            seg       <= SEG7_BLANK;
            dp        <= 1'b1;
            time_up   <= 1'b0;
        end else begin
            // Scan timing
            if (w_presc_wrap) begin
                r_presc <= '0;
                r_slot  <= slot_t'(r_slot + 2'd1);
                // Frame boundary: latch a coherent copy of the timer value.
                if (r_slot == SLOT_BLANK) begin
                    r_sh_min  <= min;
                    r_sh_sec1 <= sec1;
                    r_sh_sec2 <= sec2;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // Outputs reflect the pre-edge prescaler/slot state.
            if (w_in_guard || (r_slot == SLOT_BLANK) || !w_phase_next) begin
                an <= AN_OFF;
            end else begin
                an <= slot_anode(r_slot);
            end

            seg     <= (w_in_guard || (r_slot == SLOT_BLANK)) ? SEG7_BLANK : w_glyph;
            dp      <= ~(!w_in_guard && (r_slot == SLOT_MIN));
            time_up <= w_live_zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_timer_display_scan                                        |
// | Description : Self-checking bench for timer_display_scan. A behavioural    |
// |               model predicts each cycle's outputs into a queue; the queue  |
// |               is drained and compared on the falling edge.                 |
// |               Blink expectations apply when TIMEUP_BLINK_EN is defined.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_timer_display_scan;

    localparam int SCAN_DIV  = 8;
    localparam int GUARD     = 2;
    localparam int BLINK_DIV = 20;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] min  = 4'd0;
    logic [3:0] sec1 = 4'd0;
    logic [3:0] sec2 = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       time_up;

    timer_display_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BLINK_DIV (BLINK_DIV)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .min     (min),
        .sec1    (sec1),
        .sec2    (sec2),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .time_up (time_up)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_tu;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (state the DUT holds before the next edge)
    int         m_presc;
    int         m_slot;
    logic [3:0] m_min, m_sec1, m_sec2;
    logic       m_tu_q;
    int         m_tu_run;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_reset();
        m_presc  = 0;
        m_slot   = 0;
        m_min    = 4'd0;
        m_sec1   = 4'd0;
        m_sec2   = 4'd0;
        m_tu_q   = 1'b0;
        m_tu_run = 0;
        sb_q.delete();
    endtask

    // Predict outputs after the coming rising edge, then advance the model.
    task automatic model_push();
        exp_t e;
        logic live0;
        live0 = (min == 4'd0) && (sec1 == 4'd0) && (sec2 == 4'd0);
        // consecutive edges (including this one) that see time_up high
        if (m_tu_q) m_tu_run++;
        else        m_tu_run = 0;

        e.e_an  = 4'b1111;
        e.e_seg = 7'h7F;
        e.e_dp  = 1'b1;
        if ((m_presc >= GUARD) && (m_slot != 3)) begin
            e.e_an = ~(4'b0001 << m_slot);
            case (m_slot)
                0:       e.e_seg = glyph(m_sec2);
                1:       e.e_seg = glyph(m_sec1);
                default: e.e_seg = glyph(m_min);
            endcase
            e.e_dp = (m_slot == 2) ? 1'b0 : 1'b1;
        end
`ifdef TIMEUP_BLINK_EN
        // cycles 21-40, 61-80, ... after time_up rises are dark
        if (((m_tu_run / BLINK_DIV) % 2) == 1) e.e_an = 4'b1111;
`endif
        e.e_tu = live0;
        sb_q.push_back(e);

        if (m_presc == SCAN_DIV - 1) begin
            m_presc = 0;
            if (m_slot == 3) begin
                m_min  = min;
                m_sec1 = sec1;
                m_sec2 = sec2;
            end
            m_slot = (m_slot + 1) % 4;
        end else begin
            m_presc++;
        end
        m_tu_q = live0;
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_push();
            @(posedge clk);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("an",      an,      e.e_an);
                check_val("seg",     seg,     e.e_seg);
                check_val("dp",      dp,      e.e_dp);
                check_val("time_up", time_up, e.e_tu);
            end
        end
    endtask

    task automatic set_time(input logic [3:0] m, input logic [3:0] s1, input logic [3:0] s2);
        min  = m;
        sec1 = s1;
        sec2 = s2;
    endtask

    initial begin
        int wait_cnt;

        // power-on reset
        set_time(4'd2, 4'd0, 4'd0);
        #1 rst = 1'b0;
        #1;
        check_val("rst_an",      an,      32'hF);
        check_val("rst_seg",     seg,     32'h7F);
        check_val("rst_dp",      dp,      32'd1);
        check_val("rst_time_up", time_up, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // 2:00 held: first frame shows 0:00, then 2.00
        run_cycles(70);

        // 1:59 latched, then change to 1:58 in the middle of slot 1
        set_time(4'd1, 4'd5, 4'd9);
        run_cycles(32);
        wait_cnt = 0;
        while (!((m_slot == 1) && (m_presc == 4)) && (wait_cnt < 64)) begin
            run_cycles(1);
            wait_cnt++;
        end
        check_val("reach_slot1", (wait_cnt < 64), 32'd1);
        set_time(4'd1, 4'd5, 4'd8);
        run_cycles(48);

        // non-BCD units digit shows a dash
        set_time(4'd1, 4'd5, 4'hB);
        run_cycles(64);

        // sweep all glyphs across the three digit positions
        for (int d = 0; d < 10; d++) begin
            set_time(4'(d), 4'((d + 3) % 10), 4'(9 - d));
            run_cycles(32);
        end

        // asynchronous reset mid-slot
        run_cycles(5);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_an",      an,      32'hF);
        check_val("mid_rst_seg",     seg,     32'h7F);
        check_val("mid_rst_dp",      dp,      32'd1);
        check_val("mid_rst_time_up", time_up, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run_cycles(40);

        // time up
        set_time(4'd0, 4'd0, 4'd0);
        run_cycles(100);

`ifdef TIMEUP_BLINK_EN
        wait_cnt = 0;
        while ((((m_tu_run / BLINK_DIV) % 2) == 0) && (wait_cnt < 64)) begin
            run_cycles(1);
            wait_cnt++;
        end
        check_val("reach_blink_off", (wait_cnt < 64), 32'd1);
`endif
        // leave 0:00 (possibly while dark)
        set_time(4'd2, 4'd0, 4'd0);
        run_cycles(48);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
